seg7_scan_driver: RTL and testbench

//  Time-multiplexed driver for an N-digit common-anode seven-segment display.
//  Hex nibbles are loaded in one shot. The block scans digits at a programmable rate.
//  It supports leading-zero blanking and per-digit decimal points.
//  It sits between the datapath/debug registers and the board display pins.

---
 rtl/seg7_scan_driver.sv | 214 +++++++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : seg7_scan_driver
// Description : Time-multiplexed driver for an N-digit common-anode
//               seven-segment display. Hex nibbles are loaded in one shot
//               into a pending buffer and promoted to the displayed (shadow)
//               buffer only at frame boundaries, so a frame never mixes two
//               loads. Digits are scanned at a programmable rate, with
//               optional leading-zero blanking and per-digit decimal points.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1           system clock, rising edge
//   rst_n        in   1           asynchronous active-low reset
//   value        in   4*N_DIGITS  hex nibbles, value[3:0] = digit 0 (right)
//   dp_in        in   N_DIGITS    decimal point per digit, 1 = lit
//   load         in   1           1-cycle strobe capturing value/dp_in
//   enable       in   1           1 = scan, 0 = display dark
//   lz_blank_en  in   1           1 = blank leading zero digits
//   an           out  N_DIGITS    digit anodes, active low, one-hot-low
//   segment      out  8           {a,b,c,d,e,f,g,dp}, active low
//   frame_done   out  1           1-cycle pulse per completed frame
// ============================================================================
module seg7_scan_driver #(
  parameter int N_DIGITS = 8,
  parameter int CLK_DIV  = 100000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  load,
  input  logic                  enable,
  input  logic                  lz_blank_en,
  output logic [N_DIGITS-1:0]   an,
  output logic [7:0]            segment,
  output logic                  frame_done
);

  localparam int c_presc_w = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int c_idx_w   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int c_val_w   = 4 * N_DIGITS;

  localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(CLK_DIV - 1);
  localparam logic [c_idx_w-1:0]   c_idx_last   = c_idx_w'(N_DIGITS - 1);

  // Segment pattern {a..g} for a hex nibble, active low, without the dp bit.
  function automatic logic [6:0] glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'h01;
      4'h1: g = 7'h4F;
      4'h2: g = 7'h12;
      4'h3: g = 7'h06;
      4'h4: g = 7'h4C;
      4'h5: g = 7'h24;
      4'h6: g = 7'h20;
      4'h7: g = 7'h0F;
      4'h8: g = 7'h00;
      4'h9: g = 7'h04;
      4'hA: g = 7'h08;
      4'hB: g = 7'h60;
      4'hC: g = 7'h31;
      4'hD: g = 7'h42;
      4'hE: g = 7'h30;
      default: g = 7'h38;
    endcase
    return g;
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [c_presc_w-1:0] prescaler_q, prescaler_d;
  logic [c_idx_w-1:0]   idx_q, idx_d;
  logic [c_val_w-1:0]   pend_val_q, pend_val_d;
  logic [N_DIGITS-1:0]  pend_dp_q, pend_dp_d;
  logic                 pend_valid_q, pend_valid_d;
  logic [c_val_w-1:0]   shad_val_q, shad_val_d;
  logic [N_DIGITS-1:0]  shad_dp_q, shad_dp_d;
  logic [N_DIGITS-1:0]  an_q, an_d;
  logic [7:0]           seg_q, seg_d;
  logic                 frame_done_q, frame_done_d;

  logic                 w_tick;
  logic                 w_wrap;
  logic                 w_commit;
  logic                 w_all_zero;
  logic [N_DIGITS-1:0]  w_zero_from;
  logic [3:0]           w_nib;
  logic                 w_dp;
  logic                 w_blank;

  // --------------------------------------------------------------------------
  // Scan timing and buffer management
  // --------------------------------------------------------------------------
  always_comb begin
    w_tick   = enable && (prescaler_q == c_presc_last);
    w_wrap   = w_tick && (idx_q == c_idx_last);
    // Shadow may only change when the display is about to restart at digit 0
    // or is dark, so a frame never shows two different loads.
    w_commit = w_wrap || !enable;

    prescaler_d  = prescaler_q;
    idx_d        = idx_q;
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    shad_val_d   = shad_val_q;
    shad_dp_d    = shad_dp_q;
    frame_done_d = w_wrap;

    if (!enable) begin
      prescaler_d = '0;
      idx_d       = '0;
    end else if (w_tick) begin
      prescaler_d = '0;
      idx_d       = w_wrap ? '0 : idx_q + 1'b1;
    end else begin
      prescaler_d = prescaler_q + 1'b1;
    end

    if (load) begin
      pend_val_d = value;
      pend_dp_d  = dp_in;
    end

    if (load && w_commit) begin
      // A load landing on a commit point goes straight to the display and
      // supersedes anything still pending.
      shad_val_d   = value;
      shad_dp_d    = dp_in;
      pend_valid_d = 1'b0;
    end else if (load) begin
      pend_valid_d = 1'b1;
    end else if (w_commit && pend_valid_q) begin
      shad_val_d   = pend_val_q;
      shad_dp_d    = pend_dp_q;
      pend_valid_d = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Leading-zero detection: w_zero_from[k] = nibbles k..N-1 are all zero
  // --------------------------------------------------------------------------
  always_comb begin
    w_all_zero  = 1'b1;
    w_zero_from = '0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      w_all_zero     = w_all_zero && (shad_val_q[4*k +: 4] == 4'h0);
      w_zero_from[k] = w_all_zero;
    end
  end

  // --------------------------------------------------------------------------
  // Digit select and output decode (registered one cycle behind idx)
  // --------------------------------------------------------------------------
  always_comb begin
    w_nib   = 4'h0;
    w_dp    = 1'b0;
    w_blank = 1'b0;
    an_d    = '1;
    seg_d   = 8'hFF;

    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_q == c_idx_w'(i)) begin
        w_nib   = shad_val_q[4*i +: 4];
        w_dp    = shad_dp_q[i];
        // Digit 0 always shows, so an all-zero value still reads "0".
        w_blank = lz_blank_en && (i != 0) && w_zero_from[i];
        an_d[i] = 1'b0;
      end
    end

    if (enable) begin
      seg_d = w_blank ? {7'h7F, ~w_dp} : {glyph(w_nib), ~w_dp};
    end else begin
      an_d = '1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler_q  <= '0;
      idx_q        <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
      shad_val_q   <= '0;
      shad_dp_q    <= '0;
      an_q         <= '1;
      seg_q        <= 8'hFF;
      frame_done_q <= 1'b0;
    end else begin
      prescaler_q  <= prescaler_d;
      idx_q        <= idx_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
      shad_val_q   <= shad_val_d;
      shad_dp_q    <= shad_dp_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign segment    = seg_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_driver
// Description : Directed bench for seg7_scan_driver (N_DIGITS=4, CLK_DIV=4).
//               Stimulus queues the hand-computed {an,segment} sequence; a
//               negedge monitor pops one entry whenever the display output
//               changes, and also checks digit hold time and frame_done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

  localparam int N_DIGITS = 4;
  localparam int CLK_DIV  = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        load;
  logic        enable;
  logic        lz_blank_en;
  logic [3:0]  an;
  logic [7:0]  segment;
  logic        frame_done;

  seg7_scan_driver #(
    .N_DIGITS (N_DIGITS),
    .CLK_DIV  (CLK_DIV)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .value       (value),
    .dp_in       (dp_in),
    .load        (load),
    .enable      (enable),
    .lz_blank_en (lz_blank_en),
    .an          (an),
    .segment     (segment),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  logic [11:0] exp_q[$];
  int          n_checks = 0;
  int          n_err    = 0;
  int          exp_fd   = 0;
  int          fd_seen  = 0;
  bit          mon_on   = 1'b0;

  // Monitor state
  logic [11:0] prev = {4'hF, 8'hFF};
  logic [11:0] cur;
  logic [11:0] e;
  int          hold = 0;
  int          cyc_n = 0;
  int          last_fd = 0;
  bit          last_fd_valid = 1'b0;

  always @(negedge clk) begin
    if (mon_on) begin
      cyc_n++;
      cur = {an, segment};
      if (frame_done === 1'b1) begin
        fd_seen++;
        n_checks++;
        if (an !== 4'b0111) begin
          n_err++;
          $display("FAIL fd_align: an=%b at frame_done, expected 0111", an);
        end
        if (last_fd_valid) begin
          n_checks++;
          if (cyc_n - last_fd != 16) begin
            n_err++;
            $display("FAIL fd_period: got %0d clk, expected 16", cyc_n - last_fd);
          end
        end
        last_fd_valid = 1'b1;
        last_fd       = cyc_n;
      end
      if (frame_done !== 1'b0 && frame_done !== 1'b1) begin
        n_checks++;
        n_err++;
        $display("FAIL fd_known: frame_done=%b", frame_done);
      end
      if (!enable || !rst_n) last_fd_valid = 1'b0;

      if (cur !== prev) begin
        if (prev[11:8] != 4'hF && cur[11:8] != 4'hF) begin
          n_checks++;
          if (hold != CLK_DIV) begin
            n_err++;
            $display("FAIL hold: digit an=%b held %0d clk, expected %0d",
                     prev[11:8], hold, CLK_DIV);
          end
        end
        n_checks++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_out: an=%b seg=%h, expected nothing", an, segment);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            n_err++;
            $display("FAIL scan_out: an=%b seg=%h, expected an=%b seg=%h",
                     an, segment, e[11:8], e[7:0]);
          end
        end
        hold = 1;
      end else begin
        hold++;
      end
      prev = cur;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_frame(input logic [7:0] s0, input logic [7:0] s1,
                            input logic [7:0] s2, input logic [7:0] s3);
    exp_q.push_back({4'b1110, s0});
    exp_q.push_back({4'b1101, s1});
    exp_q.push_back({4'b1011, s2});
    exp_q.push_back({4'b0111, s3});
  endtask

  task automatic push_dark();
    exp_q.push_back({4'hF, 8'hFF});
  endtask

  // Called at posedge+1 with enable low; leaves enable low at posedge+1.
  task automatic load_val(input logic [15:0] v, input logic [3:0] dp);
    value = v;
    dp_in = dp;
    load  = 1'b1;
    @(posedge clk); #1;
    load  = 1'b0;
  endtask

  task automatic scan_frames(input int k);
    enable = 1'b1;
    repeat (16 * k) @(posedge clk);
    #1 enable = 1'b0;
    exp_fd += k;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; enable = 1'b0; load = 1'b0; lz_blank_en = 1'b0;
    value = '0; dp_in = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_an",  32'(an),         32'hF);
    chk("reset_seg", 32'(segment),    32'hFF);
    chk("reset_fd",  32'(frame_done), 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    mon_on = 1'b1;

    // Basic scan: 12AF -> digits F,A,2,1
    load_val(16'h12AF, 4'h0);
    push_frame(8'h71, 8'h11, 8'h25, 8'h9F);
    push_frame(8'h71, 8'h11, 8'h25, 8'h9F);
    push_dark();
    scan_frames(2);

    // Leading-zero blanking
    lz_blank_en = 1'b1;
    load_val(16'h0030, 4'h0);
    push_frame(8'h03, 8'h0D, 8'hFF, 8'hFF);
    push_dark();
    scan_frames(1);
    load_val(16'h0000, 4'h0);
    push_frame(8'h03, 8'hFF, 8'hFF, 8'hFF);
    push_dark();
    scan_frames(1);

    // Decimal points, including one on a blanked digit
    load_val(16'h0200, 4'b0100);
    push_frame(8'h03, 8'h03, 8'h24, 8'hFF);
    push_dark();
    scan_frames(1);
    load_val(16'h0001, 4'b1000);
    push_frame(8'h9F, 8'hFF, 8'hFF, 8'hFE);
    push_dark();
    scan_frames(1);

    // Frame-atomic loads: mid-frame load waits, wrap-coincident load is immediate
    lz_blank_en = 1'b0;
    load_val(16'h1111, 4'h0);
    push_frame(8'h9F, 8'h9F, 8'h9F, 8'h9F);
    push_frame(8'h25, 8'h25, 8'h25, 8'h25);
    push_frame(8'h0D, 8'h0D, 8'h0D, 8'h0D);
    push_dark();
    enable = 1'b1;
    repeat (4) @(posedge clk);
    #1 value = 16'h2222; load = 1'b1;
    @(posedge clk); #1 load = 1'b0;
    repeat (26) @(posedge clk);
    #1 value = 16'h3333; load = 1'b1;
    @(posedge clk); #1 load = 1'b0;
    repeat (16) @(posedge clk);
    #1 enable = 1'b0;
    exp_fd += 3;
    repeat (3) @(posedge clk);
    #1;

    // Enable drop at idx=2, pending flushed while dark, clean restart
    load_val(16'h4567, 4'h0);
    exp_q.push_back({4'b1110, 8'h1F});
    exp_q.push_back({4'b1101, 8'h41});
    push_dark();
    enable = 1'b1;
    repeat (5) @(posedge clk);
    #1 value = 16'h89AB; load = 1'b1;
    @(posedge clk); #1 load = 1'b0;
    repeat (2) @(posedge clk);
    #1 enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    push_frame(8'hC1, 8'h11, 8'h09, 8'h01);
    push_dark();
    scan_frames(1);

    // Asynchronous reset mid-scan clears all state
    exp_q.push_back({4'b1110, 8'hC1});
    exp_q.push_back({4'b1101, 8'h11});
    push_dark();
    enable = 1'b1;
    repeat (6) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_an",  32'(an),         32'hF);
    chk("async_rst_seg", 32'(segment),    32'hFF);
    chk("async_rst_fd",  32'(frame_done), 32'h0);
    enable = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    push_frame(8'h03, 8'h03, 8'h03, 8'h03);
    push_dark();
    scan_frames(1);

    repeat (5) @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    chk("frame_done_count", 32'(fd_seen), 32'(exp_fd));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
